// File: rtl/lc4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lc4_pkg                                                       |
// | Purpose  : Shared LC4 constants for the writeback stage: 4-bit major     |
// |            opcodes, 5-bit sub-opcodes (JSR/JSRR, JMP/JMPR), NZP          |
// |            encodings and the NZP value loaded at reset.                  |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package lc4_pkg;

    // Major opcodes, insn[15:12]
    localparam logic [3:0] c_op_br      = 4'b0000;
    localparam logic [3:0] c_op_add     = 4'b0001;
    localparam logic [3:0] c_op_cmp     = 4'b0010;
    localparam logic [3:0] c_op_jsr_grp = 4'b0100;
    localparam logic [3:0] c_op_logic   = 4'b0101;
    localparam logic [3:0] c_op_ldr     = 4'b0110;
    localparam logic [3:0] c_op_str     = 4'b0111;
    localparam logic [3:0] c_op_rti     = 4'b1000;
    localparam logic [3:0] c_op_const   = 4'b1001;
    localparam logic [3:0] c_op_shift   = 4'b1010;
    localparam logic [3:0] c_op_jmp_grp = 4'b1100;
    localparam logic [3:0] c_op_hiconst = 4'b1101;
    localparam logic [3:0] c_op_trap    = 4'b1111;

    // Sub-opcodes, insn[15:11]
    localparam logic [4:0] c_op5_jsrr   = 5'b01000;
    localparam logic [4:0] c_op5_jsr    = 5'b01001;
    localparam logic [4:0] c_op5_jmpr   = 5'b11000;
    localparam logic [4:0] c_op5_jmp    = 5'b11001;

    // NZP encodings
    localparam logic [2:0] c_nzp_n      = 3'b100;
    localparam logic [2:0] c_nzp_z      = 3'b010;
    localparam logic [2:0] c_nzp_p      = 3'b001;
    localparam logic [2:0] c_nzp_reset  = c_nzp_z;

    // Link register written by JSR, JSRR and TRAP
    localparam logic [2:0] c_link_reg   = 3'd7;

endpackage : lc4_pkg
`default_nettype wire

// File: rtl/lc4_wb_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lc4_wb_decode                                                 |
// | Purpose  : Purely combinational opcode classification for the LC4        |
// |            writeback stage.                                              |
// | Ports    : i_op5       - insn[15:11]                                     |
// |            o_we        - instruction writes the register file            |
// |            o_link      - write R7 with PC+1 (JSR, JSRR, TRAP)            |
// |            o_mem_ld    - LDR                                             |
// |            o_mem_st    - STR                                             |
// |            o_nzp_upd   - instruction updates NZP                         |
// |            o_br        - conditional branch (taken resolved by caller)   |
// |            o_jump      - unconditional redirect (JMP/JMPR/JSR/JSRR/TRAP) |
// |            o_rti       - RTI                                             |
// |            o_trap      - TRAP                                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module lc4_wb_decode
    import lc4_pkg::*;
(
    input  logic [4:0] i_op5,
    output logic       o_we,
    output logic       o_link,
    output logic       o_mem_ld,
    output logic       o_mem_st,
    output logic       o_nzp_upd,
    output logic       o_br,
    output logic       o_jump,
    output logic       o_rti,
    output logic       o_trap
);

    logic [3:0] w_op4;
    logic       w_cmp;

    assign w_op4 = i_op5[4:1];

    always_comb begin
        o_we     = 1'b0;
        o_link   = 1'b0;
        o_mem_ld = 1'b0;
        o_mem_st = 1'b0;
        o_br     = 1'b0;
        o_jump   = 1'b0;
        o_rti    = 1'b0;
        o_trap   = 1'b0;
        w_cmp    = 1'b0;
        case (w_op4)
            c_op_add, c_op_logic, c_op_const, c_op_shift, c_op_hiconst: o_we = 1'b1;
            c_op_cmp: w_cmp    = 1'b1;
            c_op_ldr: o_mem_ld = 1'b1;
            c_op_str: o_mem_st = 1'b1;
            c_op_br:  o_br     = 1'b1;
            c_op_rti: o_rti    = 1'b1;
            c_op_trap: begin
                o_we   = 1'b1;
                o_link = 1'b1;
                o_jump = 1'b1;
                o_trap = 1'b1;
            end
            default: begin
                if (i_op5 == c_op5_jsr || i_op5 == c_op5_jsrr) begin
                    o_we   = 1'b1;
                    o_link = 1'b1;
                    o_jump = 1'b1;
                end
                if (i_op5 == c_op5_jmp || i_op5 == c_op5_jmpr) begin
                    o_jump = 1'b1;
                end
            end
        endcase
    end

    // Every register write sets condition codes; CMP sets them without a write.
    assign o_nzp_upd = o_we | w_cmp;

endmodule : lc4_wb_decode
`default_nettype wire

// File: rtl/lc4_wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lc4_wb_stage                                                  |
// | Purpose  : LC4 writeback stage. Holds one registered entry with a        |
// |            valid/ready handshake on both sides, produces register-file   |
// |            writes, LDR/STR requests, control-flow redirects, keeps the   |
// |            NZP register and a retired-instruction counter.               |
// | Config   : LC4_PRIV_EN - adds a privilege bit (o_priv); RTI redirects    |
// |            only while privileged, otherwise it behaves as a NOP.         |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            i_valid/o_ready       upstream handshake                      |
// |            i_insn, i_pc, i_alu_result  instruction, PC, ALU output       |
// |            o_valid/i_ready       downstream handshake                    |
// |            o_we, o_rd, o_wdata   register-file write                     |
// |            o_mem_ld, o_mem_st, o_mem_addr  memory request                |
// |            o_redirect, o_redirect_pc       control-flow change           |
// |            o_nzp, o_retired      condition codes, retire count           |
// |            o_priv                privilege bit (LC4_PRIV_EN only)        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module lc4_wb_stage
    import lc4_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [15:0]          i_insn,
    input  logic [15:0]          i_pc,
    input  logic [WORD_SIZE-1:0] i_alu_result,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_we,
    output logic [2:0]           o_rd,
    output logic [WORD_SIZE-1:0] o_wdata,
    output logic                 o_mem_ld,
    output logic                 o_mem_st,
    output logic [15:0]          o_mem_addr,
    output logic                 o_redirect,
    output logic [15:0]          o_redirect_pc,
    output logic [2:0]           o_nzp,
    output logic [15:0]          o_retired
`ifdef LC4_PRIV_EN
    ,
    output logic                 o_priv
`endif
);

    logic                 r_valid;
    logic                 r_we;
    logic [2:0]           r_rd;
    logic [WORD_SIZE-1:0] r_wdata;
    logic                 r_mem_ld;
    logic                 r_mem_st;
    logic [15:0]          r_mem_addr;
    logic                 r_redirect;
    logic [15:0]          r_redirect_pc;
    logic [2:0]           r_nzp;
    logic [15:0]          r_retired;

    logic w_dec_we, w_dec_link, w_dec_ld, w_dec_st, w_dec_nzp_upd;
    logic w_dec_br, w_dec_jump, w_dec_rti, w_dec_trap;

    logic                 w_accept;
    logic                 w_retire;
    logic [2:0]           w_rd_field;
    logic [WORD_SIZE-1:0] w_wb_data;
    logic [2:0]           w_nzp_new;
    logic                 w_br_taken;
    logic                 w_rti_redirect;
    logic                 w_redirect;
    logic                 w_unused_insn_bits;

    lc4_wb_decode u_decode (
        .i_op5     (i_insn[15:11]),
        .o_we      (w_dec_we),
        .o_link    (w_dec_link),
        .o_mem_ld  (w_dec_ld),
        .o_mem_st  (w_dec_st),
        .o_nzp_upd (w_dec_nzp_upd),
        .o_br      (w_dec_br),
        .o_jump    (w_dec_jump),
        .o_rti     (w_dec_rti),
        .o_trap    (w_dec_trap)
    );

    // Immediate/offset fields are consumed upstream; only opcode and rd matter here.
    assign w_unused_insn_bits = ^i_insn[8:0];

    assign o_ready    = !r_valid || i_ready;
    assign w_accept   = i_valid && o_ready;
    assign w_retire   = r_valid && i_ready;
    assign w_rd_field = i_insn[11:9];

    assign w_wb_data  = w_dec_link ? WORD_SIZE'(i_pc + 16'd1) : i_alu_result;
    assign w_nzp_new  = w_wb_data[WORD_SIZE-1] ? c_nzp_n :
                        (w_wb_data == '0)      ? c_nzp_z : c_nzp_p;

    // Branch resolves against the NZP left by the previous accepted instruction.
    assign w_br_taken = w_dec_br && ((w_rd_field & r_nzp) != 3'b000);

`ifdef LC4_PRIV_EN
    logic r_priv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_priv <= 1'b0;
        end else if (w_accept) begin
            if (w_dec_trap) begin
                r_priv <= 1'b1;
            end else if (w_dec_rti) begin
                r_priv <= 1'b0;
            end
        end
    end

    // An unprivileged RTI degrades to a NOP.
    assign w_rti_redirect = w_dec_rti && r_priv;
    assign o_priv         = r_priv;
`else
    assign w_rti_redirect = w_dec_rti;
`endif

    assign w_redirect = w_br_taken || w_dec_jump || w_rti_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_we          <= 1'b0;
            r_rd          <= 3'd0;
            r_wdata       <= '0;
            r_mem_ld      <= 1'b0;
            r_mem_st      <= 1'b0;
            r_mem_addr    <= 16'd0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= 16'd0;
            r_nzp         <= c_nzp_reset;
            r_retired     <= 16'd0;
        end else begin
            if (w_accept) begin
                r_valid       <= 1'b1;
                r_we          <= w_dec_we;
                r_rd          <= w_dec_link ? c_link_reg : (w_dec_we ? w_rd_field : 3'd0);
                r_wdata       <= w_dec_we ? w_wb_data : '0;
                r_mem_ld      <= w_dec_ld;
                r_mem_st      <= w_dec_st;
                r_mem_addr    <= (w_dec_ld || w_dec_st) ? i_alu_result[15:0] : 16'd0;
                r_redirect    <= w_redirect;
                r_redirect_pc <= w_redirect ? i_alu_result[15:0] : 16'd0;
                if (w_dec_nzp_upd) begin
                    r_nzp <= w_nzp_new;
                end
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
            // Natural 16-bit wrap from FFFF to 0
            if (w_retire) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    assign o_valid       = r_valid;
    assign o_we          = r_we;
    assign o_rd          = r_rd;
    assign o_wdata       = r_wdata;
    assign o_mem_ld      = r_mem_ld;
    assign o_mem_st      = r_mem_st;
    assign o_mem_addr    = r_mem_addr;
    assign o_redirect    = r_redirect;
    assign o_redirect_pc = r_redirect_pc;
    assign o_nzp         = r_nzp;
    assign o_retired     = r_retired;

endmodule : lc4_wb_stage
`default_nettype wire

// File: tb/tb_lc4_wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lc4_wb_stage                                               |
// | Purpose  : Directed self-checking bench for lc4_wb_stage. Covers reset,  |
// |            ALU writeback and NZP, CMP + branch, JSR link, LDR/STR, stall |
// |            hold, retire-counter wrap, reset mid-stall and RTI/TRAP       |
// |            privilege behaviour (LC4_PRIV_EN when defined).               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_lc4_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_insn;
    logic [15:0] i_pc;
    logic [15:0] i_alu_result;
    logic        o_valid;
    logic        i_ready;
    logic        o_we;
    logic [2:0]  o_rd;
    logic [15:0] o_wdata;
    logic        o_mem_ld;
    logic        o_mem_st;
    logic [15:0] o_mem_addr;
    logic        o_redirect;
    logic [15:0] o_redirect_pc;
    logic [2:0]  o_nzp;
    logic [15:0] o_retired;
`ifdef LC4_PRIV_EN
    logic        o_priv;
`endif

    int vectors    = 0;
    int miscompares = 0;

    lc4_wb_stage #(.WORD_SIZE(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_insn        (i_insn),
        .i_pc          (i_pc),
        .i_alu_result  (i_alu_result),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_we          (o_we),
        .o_rd          (o_rd),
        .o_wdata       (o_wdata),
        .o_mem_ld      (o_mem_ld),
        .o_mem_st      (o_mem_st),
        .o_mem_addr    (o_mem_addr),
        .o_redirect    (o_redirect),
        .o_redirect_pc (o_redirect_pc),
        .o_nzp         (o_nzp),
        .o_retired     (o_retired)
`ifdef LC4_PRIV_EN
        ,
        .o_priv        (o_priv)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] insn, input logic [15:0] pc,
                         input logic [15:0] alu);
        i_valid      = v;
        i_insn       = insn;
        i_pc         = pc;
        i_alu_result = alu;
    endtask

    initial begin
        rst_n = 1'b0;
        i_ready = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        repeat (3) tick();

        // Reset state
        chk("rst_valid",   16'(o_valid),    16'h0000);
        chk("rst_nzp",     16'(o_nzp),      16'h0002);
        chk("rst_retired", o_retired,       16'h0000);
        chk("rst_ready",   16'(o_ready),    16'h0001);
        chk("rst_we",      16'(o_we),       16'h0000);
        chk("rst_redir",   16'(o_redirect), 16'h0000);

        #2 rst_n = 1'b1;

        // ADD R0 with negative result, accepted on the first edge after reset release
        drive(1'b1, 16'h1042, 16'h0000, 16'h8000);
        tick();
        chk("add_valid", 16'(o_valid), 16'h0001);
        chk("add_we",    16'(o_we),    16'h0001);
        chk("add_rd",    16'(o_rd),    16'h0000);
        chk("add_wdata", o_wdata,      16'h8000);
        chk("add_nzp",   16'(o_nzp),   16'h0004);

        // CMP with zero result: no write, NZP -> Z
        drive(1'b1, 16'h2000, 16'h0001, 16'h0000);
        tick();
        chk("cmp_we",      16'(o_we),       16'h0000);
        chk("cmp_nzp",     16'(o_nzp),      16'h0002);
        chk("cmp_redir",   16'(o_redirect), 16'h0000);
        chk("cmp_retired", o_retired,       16'h0001);

        // BRz taken on the Z left by CMP
        drive(1'b1, 16'h0405, 16'h0002, 16'h0040);
        tick();
        chk("brz_redir", 16'(o_redirect), 16'h0001);
        chk("brz_pc",    o_redirect_pc,   16'h0040);
        chk("brz_nzp",   16'(o_nzp),      16'h0002);
        chk("brz_we",    16'(o_we),       16'h0000);

        // BRn not taken with Z set
        drive(1'b1, 16'h0805, 16'h0003, 16'h0050);
        tick();
        chk("brn_redir", 16'(o_redirect), 16'h0000);
        chk("brn_pc",    o_redirect_pc,   16'h0000);

        // JSR: link R7 = PC+1, redirect to ALU target, NZP from PC+1 (positive)
        drive(1'b1, 16'h4800, 16'h0010, 16'h0200);
        tick();
        chk("jsr_we",    16'(o_we),       16'h0001);
        chk("jsr_rd",    16'(o_rd),       16'h0007);
        chk("jsr_wdata", o_wdata,         16'h0011);
        chk("jsr_redir", 16'(o_redirect), 16'h0001);
        chk("jsr_pc",    o_redirect_pc,   16'h0200);
        chk("jsr_nzp",   16'(o_nzp),      16'h0001);

        // LDR: load request, no write, NZP unchanged
        drive(1'b1, 16'h6000, 16'h0200, 16'h1234);
        tick();
        chk("ldr_ld",   16'(o_mem_ld), 16'h0001);
        chk("ldr_st",   16'(o_mem_st), 16'h0000);
        chk("ldr_addr", o_mem_addr,    16'h1234);
        chk("ldr_we",   16'(o_we),     16'h0000);
        chk("ldr_nzp",  16'(o_nzp),    16'h0001);

        // STR
        drive(1'b1, 16'h7000, 16'h0201, 16'h2222);
        tick();
        chk("str_st",      16'(o_mem_st), 16'h0001);
        chk("str_ld",      16'(o_mem_ld), 16'h0000);
        chk("str_addr",    o_mem_addr,    16'h2222);
        chk("str_retired", o_retired,     16'h0006);

        // Stall three cycles with a new ADD R3 waiting upstream
        drive(1'b1, 16'h1600, 16'h0202, 16'h0005);
        i_ready = 1'b0;
        #1;
        chk("stall_ready", 16'(o_ready), 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid",   16'(o_valid),  16'h0001);
            chk("stall_st",      16'(o_mem_st), 16'h0001);
            chk("stall_addr",    o_mem_addr,    16'h2222);
            chk("stall_retired", o_retired,     16'h0006);
            chk("stall_ready2",  16'(o_ready),  16'h0000);
        end

        // Release: STR retires, ADD R3 enters in the same edge
        i_ready = 1'b1;
        tick();
        chk("rel_retired", o_retired,     16'h0007);
        chk("rel_we",      16'(o_we),     16'h0001);
        chk("rel_rd",      16'(o_rd),     16'h0003);
        chk("rel_wdata",   o_wdata,       16'h0005);
        chk("rel_st",      16'(o_mem_st), 16'h0000);
        chk("rel_nzp",     16'(o_nzp),    16'h0001);

        // Drain
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        tick();
        chk("drain_valid",   16'(o_valid), 16'h0000);
        chk("drain_retired", o_retired,    16'h0008);

        // Stream NOPs: first edge fills, each later edge retires one (8 + 65527 = FFFF)
        drive(1'b1, 16'h0000, 16'h0000, 16'h0000);
        repeat (65528) tick();
        chk("wrap_pre", o_retired, 16'hFFFF);
        tick();
        chk("wrap_post", o_retired, 16'h0000);

        // ADD R0 negative, then hold it and reset mid-stall
        drive(1'b1, 16'h1042, 16'h0000, 16'h8000);
        tick();
        chk("pre_rst_nzp", 16'(o_nzp), 16'h0004);
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        i_ready = 1'b0;
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid",   16'(o_valid),   16'h0000);
        chk("mrst_nzp",     16'(o_nzp),     16'h0002);
        chk("mrst_retired", o_retired,      16'h0000);
        chk("mrst_we",      16'(o_we),      16'h0000);
        #2 rst_n = 1'b1;
        i_ready = 1'b1;

        // JMP: unconditional redirect, NZP untouched
        drive(1'b1, 16'hC800, 16'h0030, 16'h0444);
        tick();
        chk("jmp_valid", 16'(o_valid),    16'h0001);
        chk("jmp_redir", 16'(o_redirect), 16'h0001);
        chk("jmp_pc",    o_redirect_pc,   16'h0444);
        chk("jmp_nzp",   16'(o_nzp),      16'h0002);

        // RTI before any TRAP
        drive(1'b1, 16'h8000, 16'h0031, 16'h0300);
        tick();
`ifdef LC4_PRIV_EN
        chk("rti0_redir", 16'(o_redirect), 16'h0000);
        chk("rti0_pc",    o_redirect_pc,   16'h0000);
        chk("rti0_priv",  16'(o_priv),     16'h0000);
`else
        chk("rti0_redir", 16'(o_redirect), 16'h0001);
        chk("rti0_pc",    o_redirect_pc,   16'h0300);
`endif
        chk("rti0_nzp", 16'(o_nzp), 16'h0002);

        // TRAP: link R7 = PC+1, redirect to vector
        drive(1'b1, 16'hF0FF, 16'h0020, 16'h8000);
        tick();
        chk("trap_rd",    16'(o_rd),       16'h0007);
        chk("trap_wdata", o_wdata,         16'h0021);
        chk("trap_redir", 16'(o_redirect), 16'h0001);
        chk("trap_pc",    o_redirect_pc,   16'h8000);
        chk("trap_nzp",   16'(o_nzp),      16'h0001);
`ifdef LC4_PRIV_EN
        chk("trap_priv",  16'(o_priv),     16'h0001);
`endif

        // RTI after TRAP always redirects
        drive(1'b1, 16'h8000, 16'h8000, 16'h0300);
        tick();
        chk("rti1_redir", 16'(o_redirect), 16'h0001);
        chk("rti1_pc",    o_redirect_pc,   16'h0300);
        chk("rti1_we",    16'(o_we),       16'h0000);
`ifdef LC4_PRIV_EN
        chk("rti1_priv",  16'(o_priv),     16'h0000);
`endif
        chk("rti1_retired", o_retired, 16'h0003);

        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_lc4_wb_stage
`default_nettype wire
